// File: rtl/mux_scan_collector.sv
// Scans a bank of flops through an external select mux, one bit per clock, and
// hands each assembled word to a consumer through a double-buffered valid/ready register.
module mux_scan_collector #(
    parameter int unsigned N_BITS = 8,
    parameter int unsigned SEL_W  = 3
) (
    input  logic              C,
    input  logic              R,
    input  logic              start,
    input  logic              scan_in,
    output logic [SEL_W-1:0]  sel_mux,
    output logic              busy,
    output logic [N_BITS-1:0] data,
    output logic              valid,
    input  logic              ready,
    output logic              overrun
);

    typedef enum logic [0:0] {StIdle, StScan} state_e;

    localparam logic [SEL_W-1:0] LastSel = SEL_W'(N_BITS - 1);

    state_e            state_q, state_d;
    logic [SEL_W-1:0]  sel_q, sel_d;
    logic [N_BITS-1:0] buf_q, buf_d;
    logic [N_BITS-1:0] data_q, data_d;
    logic              valid_q, valid_d;
    logic              overrun_q, overrun_d;
    logic              complete;

    assign complete = (state_q == StScan) && (sel_q == LastSel);

    always_comb begin
        state_d   = state_q;
        sel_d     = sel_q;
        buf_d     = buf_q;
        data_d    = data_q;
        valid_d   = valid_q;
        overrun_d = overrun_q;

        unique case (state_q)
            StIdle: begin
                sel_d = '0;
                if (start) state_d = StScan;
            end
            StScan: begin
                buf_d[sel_q] = scan_in;
                sel_d        = sel_q + 1'b1;
                if (complete) begin
                    sel_d   = '0;
                    // Holding start chains the next scan with no idle cycle.
                    state_d = start ? StScan : StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        // buf_d already carries the final bit, so the word is complete here.
        if (complete) begin
            if (!valid_q || ready) begin
                data_d  = buf_d;
                valid_d = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end else if (valid_q && ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge C or negedge R) begin
        if (!R) begin
            state_q   <= StIdle;
            sel_q     <= '0;
            buf_q     <= '0;
            data_q    <= '0;
            valid_q   <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            sel_q     <= sel_d;
            buf_q     <= buf_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            overrun_q <= overrun_d;
        end
    end

    assign sel_mux = sel_q;
    assign busy    = (state_q == StScan);
    assign data    = data_q;
    assign valid   = valid_q;
    assign overrun = overrun_q;

endmodule

// File: tb/tb_mux_scan_collector.sv
// Directed bench for mux_scan_collector: a word-level model of scans and the output
// handshake is checked every cycle, alongside hand-computed expectations.
module tb_mux_scan_collector;

    logic       C = 1'b0;
    logic       R = 1'b0;
    logic       start = 1'b0;
    logic       ready = 1'b0;
    logic [7:0] pattern = 8'h00;
    logic       scan_in;
    logic [2:0] sel_mux;
    logic       busy;
    logic [7:0] data;
    logic       valid;
    logic       overrun;

    int vectors = 0;
    int miscompares = 0;

    always #5 C = ~C;

    // Upstream flop bank seen through its select mux.
    assign scan_in = pattern[sel_mux];

    mux_scan_collector #(.N_BITS(8), .SEL_W(3)) dut (
        .C       (C),
        .R       (R),
        .start   (start),
        .scan_in (scan_in),
        .sel_mux (sel_mux),
        .busy    (busy),
        .data    (data),
        .valid   (valid),
        .ready   (ready),
        .overrun (overrun)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Word-level model: samples taken so far in the current scan and the word they form.
    logic       m_busy, m_valid, m_ovr;
    logic [2:0] m_cnt;
    logic [7:0] m_acc, m_data, m_word;

    assign m_word = m_acc | ({7'd0, pattern[m_cnt]} << m_cnt);

    always @(posedge C or negedge R) begin
        if (!R) begin
            m_busy <= 1'b0; m_cnt <= 3'd0; m_acc <= 8'h00;
            m_data <= 8'h00; m_valid <= 1'b0; m_ovr <= 1'b0;
        end else if (m_busy && m_cnt == 3'd7) begin
            m_acc  <= 8'h00;
            m_cnt  <= 3'd0;
            m_busy <= start;
            if (!m_valid || ready) begin
                m_data  <= m_word;
                m_valid <= 1'b1;
            end else begin
                m_ovr <= 1'b1;
            end
        end else begin
            if (m_busy) begin
                m_acc <= m_word;
                m_cnt <= m_cnt + 3'd1;
            end else begin
                m_busy <= start;
            end
            if (m_valid && ready) m_valid <= 1'b0;
        end
    end

    always @(negedge C) begin
        chk("cyc_busy", {31'd0, busy}, {31'd0, m_busy});
        chk("cyc_sel", {29'd0, sel_mux}, {29'd0, m_cnt});
        chk("cyc_valid", {31'd0, valid}, {31'd0, m_valid});
        chk("cyc_data", {24'd0, data}, {24'd0, m_data});
        chk("cyc_overrun", {31'd0, overrun}, {31'd0, m_ovr});
    end

    task automatic tick(input int n);
        repeat (n) @(negedge C);
    endtask

    // Drives start for one edge; returns just after that edge (t0).
    task automatic pulse_start();
        start = 1'b1;
        tick(1);
        start = 1'b0;
    endtask

    int vcount;

    initial begin
        #12;
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_sel", {29'd0, sel_mux}, 32'd0);
        chk("rst_data", {24'd0, data}, 32'd0);
        chk("rst_valid", {31'd0, valid}, 32'd0);
        chk("rst_overrun", {31'd0, overrun}, 32'd0);
        tick(1);
        R = 1'b1;
        tick(2);

        // Single scan, consumer always ready.
        pattern = 8'hA5; ready = 1'b1;
        pulse_start();
        chk("a5_busy_t0", {31'd0, busy}, 32'd1);
        chk("a5_sel_t0", {29'd0, sel_mux}, 32'd0);
        tick(7);
        chk("a5_sel_t7", {29'd0, sel_mux}, 32'd7);
        chk("a5_valid_early", {31'd0, valid}, 32'd0);
        tick(1);
        chk("a5_valid", {31'd0, valid}, 32'd1);
        chk("a5_data", {24'd0, data}, 32'h0000_00A5);
        chk("a5_busy_done", {31'd0, busy}, 32'd0);
        chk("a5_overrun", {31'd0, overrun}, 32'd0);
        tick(1);
        chk("a5_consumed", {31'd0, valid}, 32'd0);
        chk("a5_data_hold", {24'd0, data}, 32'h0000_00A5);
        tick(2);

        // Back-to-back scans with start held.
        pattern = 8'h3C; start = 1'b1;
        tick(1);
        tick(8);
        chk("b2b_first", {24'd0, data}, 32'h0000_003C);
        chk("b2b_busy1", {31'd0, busy}, 32'd1);
        pattern = 8'hC3;
        for (int i = 0; i < 8; i++) begin
            chk("b2b_busy_hold", {31'd0, busy}, 32'd1);
            tick(1);
        end
        chk("b2b_second", {24'd0, data}, 32'h0000_00C3);
        chk("b2b_valid2", {31'd0, valid}, 32'd1);
        start = 1'b0;
        tick(10);
        chk("b2b_idle", {31'd0, busy}, 32'd0);

        // Overrun with consumer stalled.
        ready = 1'b0; pattern = 8'h0F;
        pulse_start();
        tick(8);
        chk("ovr_first", {24'd0, data}, 32'h0000_000F);
        pattern = 8'hF0;
        pulse_start();
        tick(8);
        chk("ovr_data_kept", {24'd0, data}, 32'h0000_000F);
        chk("ovr_flag", {31'd0, overrun}, 32'd1);
        ready = 1'b1;
        tick(1);
        chk("ovr_cleared_valid", {31'd0, valid}, 32'd0);
        chk("ovr_sticky", {31'd0, overrun}, 32'd1);
        tick(2);

        // Asynchronous reset in the middle of a scan.
        pattern = 8'h5A;
        pulse_start();
        tick(4);
        #2 R = 1'b0;
        #1;
        chk("ar_busy", {31'd0, busy}, 32'd0);
        chk("ar_sel", {29'd0, sel_mux}, 32'd0);
        chk("ar_valid", {31'd0, valid}, 32'd0);
        chk("ar_overrun", {31'd0, overrun}, 32'd0);
        tick(2);
        R = 1'b1;
        vcount = 0;
        for (int i = 0; i < 12; i++) begin
            tick(1);
            if (valid) vcount++;
        end
        chk("ar_no_valid", vcount, 32'd0);

        // Ready arrives exactly on the completion edge of the next word.
        ready = 1'b0; pattern = 8'h11;
        pulse_start();
        tick(8);
        chk("rdy_old", {24'd0, data}, 32'h0000_0011);
        pattern = 8'h22;
        pulse_start();
        tick(7);
        chk("rdy_hold", {24'd0, data}, 32'h0000_0011);
        ready = 1'b1;
        tick(1);
        ready = 1'b0;
        chk("rdy_new", {24'd0, data}, 32'h0000_0022);
        chk("rdy_valid", {31'd0, valid}, 32'd1);
        chk("rdy_overrun", {31'd0, overrun}, 32'd0);
        ready = 1'b1;
        tick(2);

        // start while busy is ignored.
        pattern = 8'h96;
        pulse_start();
        tick(2);
        start = 1'b1;
        tick(1);
        start = 1'b0;
        chk("ign_sel", {29'd0, sel_mux}, 32'd3);
        tick(5);
        chk("ign_data", {24'd0, data}, 32'h0000_0096);
        chk("ign_valid", {31'd0, valid}, 32'd1);
        vcount = 0;
        for (int i = 0; i < 12; i++) begin
            tick(1);
            if (valid || busy) vcount++;
        end
        chk("ign_one_word", vcount, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
